// File: rtl/threadbrain_pkg.sv
// Shared constants and helpers for the select stages and the data-memory arbiter.
package threadbrain_pkg;

  localparam logic [1:0] ARB_RUN   = 2'd0;
  localparam logic [1:0] ARB_DRAIN = 2'd1;
  localparam logic [1:0] ARB_IDLE  = 2'd2;

  localparam int unsigned OP_W = 3;
  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LD  = 3'd1;
  localparam logic [2:0] OP_ST  = 3'd2;
  localparam logic [2:0] OP_ALU = 3'd3;
  localparam logic [2:0] OP_BR  = 3'd4;

  // Width of a core index; never below one bit so single-core builds still have a field.
  function automatic int unsigned id_width(input int unsigned n);
    if (n <= 32'd1) return 32'd1;
    return 32'($clog2(n));
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin finder: first set bit of elig_i at or after ptr_i, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  elig_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] winner_o,
  output logic          found_o
);

  always_comb begin
    int unsigned  idx;
    logic [N-1:0] shifted;
    idx      = 0;
    shifted  = '0;
    winner_o = '0;
    found_o  = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx     = (32'(ptr_i) + k) % N;
      shifted = elig_i >> idx;
      if (!found_o && shifted[0]) begin
        found_o  = 1'b1;
        winner_o = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of the single data-memory port among the select stages,
// with load-return tracking and a drain/idle handshake for the top level.
module mem_port_arbiter
  import threadbrain_pkg::*;
#(
  parameter int unsigned NCORES = 4,
  parameter int unsigned LD_LAT = 2,
  parameter int unsigned AW     = 16,
  parameter int unsigned DW     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCORES-1:0]    req_ld,
  input  logic [NCORES-1:0]    req_st,
  input  logic [NCORES*AW-1:0] req_addr,
  input  logic [NCORES*DW-1:0] req_wdata,
  output logic [NCORES-1:0]    grant,
  output logic [NCORES-1:0]    rd_valid,
  output logic [DW-1:0]        rd_data,
  output logic                 mem_rd_en,
  output logic                 mem_wr_en,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata,
  input  logic                 drain_req,
  output logic                 idle
);

  localparam int unsigned IW = id_width(NCORES);

  logic [1:0]                state_q, state_d;
  logic [IW-1:0]             ptr_q, ptr_d;
  logic [LD_LAT-1:0]         vld_q, vld_d;
  logic [LD_LAT-1:0][IW-1:0] id_q, id_d;
  logic [IW-1:0]             winner;
  logic                      found;
  logic                      issue;

  rr_pick #(.N(NCORES), .IW(IW)) u_pick (
    .elig_i   (req_ld | req_st),
    .ptr_i    (ptr_q),
    .winner_o (winner),
    .found_o  (found)
  );

  // Issue path: a winner's store takes priority over its load, which stays pending.
  always_comb begin
    issue     = found && !rst && (state_q == ARB_RUN);
    grant     = '0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int unsigned i = 0; i < NCORES; i++) begin
      if (issue && (winner == IW'(i))) begin
        grant[i]  = 1'b1;
        mem_addr  = req_addr[i*AW +: AW];
        mem_wr_en = req_st[i];
        mem_rd_en = !req_st[i];
        mem_wdata = req_st[i] ? req_wdata[i*DW +: DW] : '0;
      end
    end
  end

  always_comb begin
    vld_d    = '0;
    id_d     = '0;
    vld_d[0] = mem_rd_en;
    id_d[0]  = winner;
    for (int unsigned s = 1; s < LD_LAT; s++) begin
      vld_d[s] = vld_q[s-1];
      id_d[s]  = id_q[s-1];
    end
    ptr_d = ptr_q;
    if (issue) begin
      ptr_d = (winner == IW'(NCORES - 1)) ? '0 : winner + 1'b1;
    end
  end

  // Drain completes once nothing will remain in the load pipeline after this cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_RUN: begin
        if (drain_req) state_d = ARB_DRAIN;
      end
      ARB_DRAIN: begin
        if (!drain_req)        state_d = ARB_RUN;
        else if (vld_d == '0)  state_d = ARB_IDLE;
      end
      ARB_IDLE: begin
        if (!drain_req) state_d = ARB_RUN;
      end
      default: state_d = ARB_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_RUN;
      ptr_q   <= '0;
      vld_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      vld_q   <= vld_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    rd_valid = '0;
    rd_data  = '0;
    if (!rst && vld_q[LD_LAT-1]) begin
      rd_data = mem_rdata;
      for (int unsigned i = 0; i < NCORES; i++) begin
        rd_valid[i] = (id_q[LD_LAT-1] == IW'(i));
      end
    end
  end

  assign idle = !rst && (state_q == ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a queue-based model.
module tb_mem_port_arbiter;

  localparam int unsigned NC  = 4;
  localparam int unsigned LAT = 2;

  typedef enum {M_RUN, M_DRAIN, M_IDLE} mode_e;
  typedef struct {int due; int core; logic [15:0] data;} ret_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NC-1:0]    req_ld, req_st, grant, rd_valid;
  logic [NC*16-1:0] req_addr, req_wdata;
  logic [15:0]      rd_data, mem_addr, mem_wdata, mem_rdata;
  logic             mem_rd_en, mem_wr_en, drain_req, idle;

  logic [0:0]  req_ld1, req_st1, grant1, rd_valid1;
  logic [15:0] req_addr1, req_wdata1, rd_data1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        mem_rd_en1, mem_wr_en1, idle1;

  int checks;
  int errors;

  mem_port_arbiter #(.NCORES(NC), .LD_LAT(LAT), .AW(16), .DW(16)) dut (
    .clk(clk), .rst(rst), .req_ld(req_ld), .req_st(req_st), .req_addr(req_addr),
    .req_wdata(req_wdata), .grant(grant), .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .drain_req(drain_req), .idle(idle)
  );

  mem_port_arbiter #(.NCORES(1), .LD_LAT(LAT), .AW(16), .DW(16)) dut1 (
    .clk(clk), .rst(rst), .req_ld(req_ld1), .req_st(req_st1), .req_addr(req_addr1),
    .req_wdata(req_wdata1), .grant(grant1), .rd_valid(rd_valid1), .rd_data(rd_data1),
    .mem_rd_en(mem_rd_en1), .mem_wr_en(mem_wr_en1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .drain_req(1'b0), .idle(idle1)
  );

  // Contents of never-written memory locations.
  function automatic logic [15:0] memfn(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  // Write-first memory with a fixed two-cycle read latency.
  bit [15:0]   env_mem [4096];
  bit [4095:0] env_wr;
  logic [15:0] rp0, rp1, rq0, rq1;
  always @(posedge clk) begin
    if (mem_wr_en) begin
      env_mem[mem_addr[11:0]] <= mem_wdata;
      env_wr[mem_addr[11:0]]  <= 1'b1;
    end
    rp0 <= !mem_rd_en ? 16'h0 :
           (env_wr[mem_addr[11:0]] ? env_mem[mem_addr[11:0]] : memfn(mem_addr));
    rp1 <= rp0;
    rq0 <= mem_rd_en1 ? memfn(mem_addr1) : 16'h0;
    rq1 <= rq0;
  end
  assign mem_rdata  = rp1;
  assign mem_rdata1 = rq1;

  bit [15:0]   ref_mem [4096];
  bit [4095:0] ref_wr;
  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_wr[a[11:0]] ? ref_mem[a[11:0]] : memfn(a);
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    req_ld = '0; req_st = '0; req_addr = '0; req_wdata = '0;
    req_ld1 = '0; req_st1 = '0; req_addr1 = '0; req_wdata1 = '0;
  endtask

  task automatic set_req(input int c, input logic ld, input logic st,
                         input logic [15:0] a, input logic [15:0] d);
    req_ld[c] = ld;
    req_st[c] = st;
    req_addr[c*16 +: 16]  = a;
    req_wdata[c*16 +: 16] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drain_req = 1'b0;
    clear_reqs();
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({grant, rd_valid, mem_rd_en, mem_wr_en, idle} !== 11'b0) begin
      errors++;
      $display("FAIL rst_ctl got %b exp 0", {grant, rd_valid, mem_rd_en, mem_wr_en, idle});
    end
    checks++;
    if ({mem_addr, mem_wdata, rd_data} !== 48'h0) begin
      errors++;
      $display("FAIL rst_data got %h exp 0", {mem_addr, mem_wdata, rd_data});
    end
    nxt();
    set_req(2, 1'b1, 1'b0, 16'h0010, 16'h0);
    @(negedge clk);
    checks++;
    if ({grant, mem_rd_en, mem_wr_en, mem_addr} !== {4'b0100, 1'b1, 1'b0, 16'h0010}) begin
      errors++;
      $display("FAIL first_ld got %b/%b%b/%h exp 0100/10/0010", grant, mem_rd_en, mem_wr_en, mem_addr);
    end
    nxt();
    clear_reqs();
    @(negedge clk);
    checks++;
    if (rd_valid !== 4'b0) begin
      errors++;
      $display("FAIL first_ld_early got %b exp 0000", rd_valid);
    end
    nxt();
    @(negedge clk);
    checks++;
    if ({rd_valid, rd_data} !== {4'b0100, 16'hBEEF}) begin
      errors++;
      $display("FAIL first_ld_ret got %b/%h exp 0100/beef", rd_valid, rd_data);
    end
    nxt();
  endtask

  task automatic test_round_robin();
    logic [NC-1:0] exp_g, exp_v;
    logic [15:0]   exp_d;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 16'(32'h0100 + i), 16'h0);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      exp_g = 4'(1 << (k % 4));
      checks++;
      if (grant !== exp_g) begin
        errors++;
        $display("FAIL rr_grant cyc %0d got %b exp %b", k, grant, exp_g);
      end
      if (k >= 2) begin
        exp_v = 4'(1 << ((k - 2) % 4));
        exp_d = memfn(16'(32'h0100 + (k - 2) % 4));
        checks++;
        if ({rd_valid, rd_data} !== {exp_v, exp_d}) begin
          errors++;
          $display("FAIL rr_ret cyc %0d got %b/%h exp %b/%h", k, rd_valid, rd_data, exp_v, exp_d);
        end
      end
      nxt();
    end
    clear_reqs();
  endtask

  task automatic test_ld_st_same();
    do_reset();
    set_req(1, 1'b1, 1'b1, 16'h0005, 16'h1234);
    @(negedge clk);
    checks++;
    if ({grant, mem_wr_en, mem_rd_en, mem_addr, mem_wdata} !== {4'b0010, 2'b10, 16'h0005, 16'h1234}) begin
      errors++;
      $display("FAIL st_first got %b/%b%b/%h/%h exp 0010/10/0005/1234",
               grant, mem_wr_en, mem_rd_en, mem_addr, mem_wdata);
    end
    nxt();
    req_st[1] = 1'b0;
    @(negedge clk);
    checks++;
    if ({grant, mem_wr_en, mem_rd_en, mem_addr} !== {4'b0010, 2'b01, 16'h0005}) begin
      errors++;
      $display("FAIL ld_after_st got %b/%b%b/%h exp 0010/01/0005", grant, mem_wr_en, mem_rd_en, mem_addr);
    end
    nxt();
    clear_reqs();
    nxt();
    @(negedge clk);
    checks++;
    if ({rd_valid, rd_data} !== {4'b0010, 16'h1234}) begin
      errors++;
      $display("FAIL ld_st_ret got %b/%h exp 0010/1234", rd_valid, rd_data);
    end
    nxt();
  endtask

  task automatic test_drain();
    do_reset();
    set_req(0, 1'b1, 1'b0, 16'h0030, 16'h0);
    nxt();
    clear_reqs();
    set_req(3, 1'b1, 1'b0, 16'h0031, 16'h0);
    drain_req = 1'b1;
    @(negedge clk);
    checks++;
    if (grant !== 4'b1000) begin
      errors++;
      $display("FAIL drain_first_grant got %b exp 1000", grant);
    end
    nxt();
    clear_reqs();
    set_req(1, 1'b1, 1'b0, 16'h0032, 16'h0);
    @(negedge clk);
    checks++;
    if ({grant, mem_rd_en, mem_wr_en, idle, rd_valid, rd_data} !== {4'b0, 3'b0, 4'b0001, memfn(16'h0030)}) begin
      errors++;
      $display("FAIL drain_c2 got %b/%b%b%b/%b/%h exp 0000/000/0001/%h",
               grant, mem_rd_en, mem_wr_en, idle, rd_valid, rd_data, memfn(16'h0030));
    end
    nxt();
    @(negedge clk);
    checks++;
    if ({grant, idle, rd_valid, rd_data} !== {4'b0, 1'b0, 4'b1000, memfn(16'h0031)}) begin
      errors++;
      $display("FAIL drain_c3 got %b/%b/%b/%h exp 0000/0/1000/%h",
               grant, idle, rd_valid, rd_data, memfn(16'h0031));
    end
    nxt();
    @(negedge clk);
    checks++;
    if ({grant, idle, rd_valid} !== {4'b0, 1'b1, 4'b0}) begin
      errors++;
      $display("FAIL drain_idle got %b/%b/%b exp 0000/1/0000", grant, idle, rd_valid);
    end
    nxt();
    drain_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({grant, idle} !== {4'b0, 1'b1}) begin
      errors++;
      $display("FAIL idle_release got %b/%b exp 0000/1", grant, idle);
    end
    nxt();
    @(negedge clk);
    checks++;
    if ({grant, idle} !== {4'b0010, 1'b0}) begin
      errors++;
      $display("FAIL resume got %b/%b exp 0010/0", grant, idle);
    end
    nxt();
    clear_reqs();
  endtask

  task automatic test_reset_flush();
    do_reset();
    set_req(2, 1'b1, 1'b0, 16'h0040, 16'h0);
    nxt();
    clear_reqs();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) req_ld = 4'b1111;
      @(negedge clk);
      checks++;
      if (rd_valid !== 4'b0) begin
        errors++;
        $display("FAIL flush_rv cyc %0d got %b exp 0000", k, rd_valid);
      end
      nxt();
      rst = 1'b0;
    end
    do_reset();
    req_ld = 4'b1111;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL flush_ptr got %b exp 0001", grant);
    end
    nxt();
    clear_reqs();
  endtask

  task automatic test_single_core();
    logic [15:0] exp_d;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      req_ld1   = 1'b1;
      req_addr1 = 16'(32'h0200 + k);
      @(negedge clk);
      checks++;
      if ({grant1, mem_rd_en1, mem_wr_en1, idle1, mem_wdata1} !== {3'b110, 1'b0, 16'h0}) begin
        errors++;
        $display("FAIL nc1_grant cyc %0d got %b%b%b%b/%h exp 1100/0000", k, grant1, mem_rd_en1,
                 mem_wr_en1, idle1, mem_wdata1);
      end
      exp_d = (k >= 2) ? memfn(16'(32'h0200 + k - 2)) : 16'h0;
      checks++;
      if ({rd_valid1, rd_data1} !== {(k >= 2) ? 1'b1 : 1'b0, exp_d}) begin
        errors++;
        $display("FAIL nc1_ret cyc %0d got %b/%h exp %0d/%h", k, rd_valid1, rd_data1, k >= 2, exp_d);
      end
      nxt();
    end
    clear_reqs();
  endtask

  task automatic test_random();
    ret_t          q[$];
    ret_t          r;
    mode_e         mode;
    int            ptr, w, c;
    logic [NC-1:0] p_ld, p_st, exp_g, exp_v;
    logic [15:0]   p_addr [NC];
    logic [15:0]   p_wd [NC];
    logic [15:0]   exp_d, exp_a, exp_w;
    logic          exp_rd, exp_wr, exp_idle;
    do_reset();
    mode = M_RUN;
    ptr  = 0;
    p_ld = '0;
    p_st = '0;
    for (int i = 0; i < NC; i++) begin p_addr[i] = 16'h0; p_wd[i] = 16'h0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NC; i++) begin
        if (!p_ld[i] && !p_st[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            p_ld[i]   = 1'($urandom_range(0, 1));
            p_st[i]   = 1'($urandom_range(0, 1));
            if (!p_st[i]) p_ld[i] = 1'b1;
            p_addr[i] = 16'(32'h0020 + $urandom_range(0, 15));
            p_wd[i]   = 16'($urandom);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          p_ld[i] = 1'b0;
          p_st[i] = 1'b0;
        end
      end
      if ($urandom_range(0, 19) == 0) drain_req = ~drain_req;
      req_ld = p_ld;
      req_st = p_st;
      for (int i = 0; i < NC; i++) begin
        req_addr[i*16 +: 16]  = p_addr[i];
        req_wdata[i*16 +: 16] = p_wd[i];
      end
      exp_v = '0; exp_d = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
        r = q.pop_front();
        exp_v[r.core] = 1'b1;
        exp_d = r.data;
      end
      w = -1;
      for (int k = 0; k < NC; k++) begin
        c = (ptr + k) % NC;
        if (w < 0 && (p_ld[c] || p_st[c])) w = c;
      end
      if (mode != M_RUN) w = -1;
      exp_g = '0; exp_rd = 1'b0; exp_wr = 1'b0; exp_a = '0; exp_w = '0;
      if (w >= 0) begin
        exp_g[w] = 1'b1;
        exp_a    = p_addr[w];
        if (p_st[w]) begin
          exp_wr = 1'b1;
          exp_w  = p_wd[w];
          ref_mem[exp_a[11:0]] = exp_w;
          ref_wr[exp_a[11:0]]  = 1'b1;
          p_st[w] = 1'b0;
        end else begin
          exp_rd = 1'b1;
          r.due = cyc + LAT; r.core = w; r.data = ref_rd(exp_a);
          q.push_back(r);
          p_ld[w] = 1'b0;
        end
        ptr = (w + 1) % NC;
      end
      exp_idle = (mode == M_IDLE);
      @(negedge clk);
      checks++;
      if (grant !== exp_g) begin
        errors++;
        $display("FAIL rnd_grant cyc %0d got %b exp %b", cyc, grant, exp_g);
      end
      checks++;
      if ({mem_rd_en, mem_wr_en, mem_addr, mem_wdata} !== {exp_rd, exp_wr, exp_a, exp_w}) begin
        errors++;
        $display("FAIL rnd_mem cyc %0d got %b%b/%h/%h exp %b%b/%h/%h", cyc, mem_rd_en, mem_wr_en,
                 mem_addr, mem_wdata, exp_rd, exp_wr, exp_a, exp_w);
      end
      checks++;
      if ({rd_valid, rd_data} !== {exp_v, exp_d}) begin
        errors++;
        $display("FAIL rnd_ret cyc %0d got %b/%h exp %b/%h", cyc, rd_valid, rd_data, exp_v, exp_d);
      end
      checks++;
      if (idle !== exp_idle) begin
        errors++;
        $display("FAIL rnd_idle cyc %0d got %b exp %b", cyc, idle, exp_idle);
      end
      case (mode)
        M_RUN:   if (drain_req) mode = M_DRAIN;
        M_DRAIN: if (!drain_req) mode = M_RUN; else if (q.size() == 0) mode = M_IDLE;
        default: if (!drain_req) mode = M_RUN;
      endcase
      nxt();
    end
    drain_req = 1'b0;
    clear_reqs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_round_robin();
    test_ld_st_same();
    test_drain();
    test_reset_flush();
    test_single_core();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
